// File: rtl/tracker_pkg.sv
// Shared dimensions, derived widths and FSM encoding for the streaming
// bright-object centroid locator.
package tracker_pkg;

    localparam int IMG_COLS_DEF = 648;
    localparam int IMG_ROWS_DEF = 488;
    localparam int DIV_W_DEF    = 28;

    // x must hold IMG_COLS itself because the column counter saturates there
    localparam int X_W   = $clog2(IMG_COLS_DEF + 1);
    localparam int Y_W   = $clog2(IMG_ROWS_DEF);
    localparam int CNT_W = $clog2(IMG_COLS_DEF * IMG_ROWS_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DIVIDE,
        ST_DONE
    } centroid_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// done is high during the cycle whose clock edge produces the final quotient bit.
module seq_divider #(
    parameter int W  = 28,
    parameter int QW = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic [QW-1:0] quotient,
    output logic          done
);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] ITER_LAST = IW'(W - 1);

    logic [W-1:0]  rem_reg;
    logic [W-1:0]  quo_reg;
    logic [W-1:0]  div_reg;
    logic [IW-1:0] iter_reg;
    logic          running_reg;

    logic [W:0] shifted;
    logic       take;

    // quo_reg doubles as the dividend shift register: its MSB feeds the remainder
    assign shifted  = {rem_reg, quo_reg[W-1]};
    assign take     = shifted >= {1'b0, div_reg};
    assign done     = running_reg && (iter_reg == ITER_LAST);
    assign quotient = quo_reg[QW-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_reg     <= '0;
            quo_reg     <= '0;
            div_reg     <= '0;
            iter_reg    <= '0;
            running_reg <= 1'b0;
        end else if (abort) begin
            running_reg <= 1'b0;
        end else if (start) begin
            rem_reg     <= '0;
            quo_reg     <= dividend;
            div_reg     <= divisor;
            iter_reg    <= '0;
            running_reg <= 1'b1;
        end else if (running_reg) begin
            rem_reg  <= take ? W'(shifted - {1'b0, div_reg}) : shifted[W-1:0];
            quo_reg  <= {quo_reg[W-2:0], take};
            iter_reg <= iter_reg + IW'(1);
            if (iter_reg == ITER_LAST) begin
                running_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_centroid.sv
// Thresholds pixels of one frame, accumulates column/row sums and the hit
// count, then divides to produce the integer centroid of the bright pixels.
module frame_centroid
    import tracker_pkg::*;
#(
    parameter int IMG_COLS = IMG_COLS_DEF,
    parameter int IMG_ROWS = IMG_ROWS_DEF,
    parameter int DIV_W    = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_start,
    input  logic [7:0]       pixel,
    input  logic             data_valid,
    input  logic             line_valid,
    input  logic [7:0]       threshold,
    output logic [X_W-1:0]   cx,
    output logic [Y_W-1:0]   cy,
    output logic [CNT_W-1:0] pix_count,
    output logic             found,
    output logic             result_valid,
    output logic             busy
);
    localparam logic [X_W-1:0] COLS_X    = X_W'(IMG_COLS);
    localparam logic [Y_W-1:0] ROWS_LAST = Y_W'(IMG_ROWS - 1);

    centroid_state_t state_reg, state_next;

    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DIV_W-1:0] sum_x_reg, sum_y_reg;
    logic             lv_d_reg;
    logic             div_start_reg;

    logic             line_end, qualify, div_start, div_done;
    logic [1:0]       div_done_vec;
    logic [X_W-1:0]   quot_x;
    logic [Y_W-1:0]   quot_y;

    assign line_end  = lv_d_reg && !line_valid;
    assign qualify   = data_valid && (x_reg < COLS_X) && (pixel >= threshold);
    assign div_start = div_start_reg && (count_reg != '0);
    assign div_done  = &div_done_vec;
    assign busy      = (state_reg != ST_IDLE);

    seq_divider #(.W(DIV_W), .QW(X_W)) u_div_x (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .abort    (frame_start),
        .dividend (sum_x_reg),
        .divisor  (DIV_W'(count_reg)),
        .quotient (quot_x),
        .done     (div_done_vec[0])
    );

    seq_divider #(.W(DIV_W), .QW(Y_W)) u_div_y (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .abort    (frame_start),
        .dividend (sum_y_reg),
        .divisor  (DIV_W'(count_reg)),
        .quotient (quot_y),
        .done     (div_done_vec[1])
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (frame_start) begin
            state_next = ST_ACCUM;
        end else begin
            case (state_reg)
                ST_ACCUM:  if (line_end && (y_reg == ROWS_LAST)) state_next = ST_DIVIDE;
                ST_DIVIDE: if ((count_reg == '0) || div_done) state_next = ST_DONE;
                ST_DONE:   state_next = ST_IDLE;
                default:   state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_reg         <= '0;
            y_reg         <= '0;
            count_reg     <= '0;
            sum_x_reg     <= '0;
            sum_y_reg     <= '0;
            lv_d_reg      <= 1'b0;
            div_start_reg <= 1'b0;
            cx            <= '0;
            cy            <= '0;
            pix_count     <= '0;
            found         <= 1'b0;
            result_valid  <= 1'b0;
        end else begin
            lv_d_reg      <= line_valid;
            // divider operands are sampled one cycle into DIVIDE, after the last pixel lands
            div_start_reg <= (state_reg == ST_ACCUM) && (state_next == ST_DIVIDE);
            result_valid  <= 1'b0;
            if (frame_start) begin
                x_reg     <= '0;
                y_reg     <= '0;
                count_reg <= '0;
                sum_x_reg <= '0;
                sum_y_reg <= '0;
            end else if (state_reg == ST_ACCUM) begin
                if (qualify) begin
                    sum_x_reg <= sum_x_reg + DIV_W'(x_reg);
                    sum_y_reg <= sum_y_reg + DIV_W'(y_reg);
                    count_reg <= count_reg + CNT_W'(1);
                end
                if (data_valid && (x_reg < COLS_X)) begin
                    x_reg <= x_reg + X_W'(1);
                end
                if (line_end) begin
                    x_reg <= '0;
                    y_reg <= y_reg + Y_W'(1);
                end
            end else if (state_reg == ST_DONE) begin
                // divider registers may hold a stale quotient when it was skipped
                cx           <= (count_reg == '0) ? '0 : quot_x;
                cy           <= (count_reg == '0) ? '0 : quot_y;
                pix_count    <= count_reg;
                found        <= (count_reg != '0);
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_centroid.sv
// Directed frames on an 8x4 configuration; a monitor checks every result pulse
// against the expected values queued by the stimulus process.
module tb_frame_centroid;
    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int DIV_W = 28;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  pixel = '0;
    logic        data_valid = 1'b0;
    logic        line_valid = 1'b0;
    logic [7:0]  threshold = 8'd128;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic [18:0] pix_count;
    logic        found;
    logic        result_valid;
    logic        busy;

    frame_centroid #(.IMG_COLS(COLS), .IMG_ROWS(ROWS), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_start  (frame_start),
        .pixel        (pixel),
        .data_valid   (data_valid),
        .line_valid   (line_valid),
        .threshold    (threshold),
        .cx           (cx),
        .cy           (cy),
        .pix_count    (pix_count),
        .found        (found),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cx;
        int cy;
        int cnt;
        int lat;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         end_cyc = 0;
    logic [7:0] img [ROWS][COLS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = v;
    endtask

    // beats > COLS drives extra bright beats past the last column
    task automatic send_frame(input int beats, input bit push, input int ecx,
                              input int ecy, input int ecnt, input int lat);
        exp_t e;
        if (push) begin
            e.cx = ecx; e.cy = ecy; e.cnt = ecnt; e.lat = lat;
            sb.push_back(e);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        tick();
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < beats; b++) begin
                line_valid = 1'b1;
                data_valid = 1'b1;
                pixel      = (b < COLS) ? img[r][b] : 8'd255;
                tick();
            end
            line_valid = 1'b0;
            data_valid = 1'b0;
            pixel      = 8'd0;
            tick();
            if (r == ROWS - 1) end_cyc = cyc;
            tick();
        end
    endtask

    task automatic wait_result();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("result_timeout_pending", sb.size(), 0);
        sb.delete();
        repeat (3) tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("result: cx=%0d cy=%0d pix_count=%0d found=%0d latency=%0d",
                             cx, cy, pix_count, found, cyc - end_cyc);
                    chk("cx", int'(cx), e.cx);
                    chk("cy", int'(cy), e.cy);
                    chk("pix_count", int'(pix_count), e.cnt);
                    chk("found", int'(found), (e.cnt != 0) ? 1 : 0);
                    chk("latency", cyc - end_cyc, e.lat);
                    chk("busy_with_result", int'(busy), 0);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) tick();
        chk("reset_cx", int'(cx), 0);
        chk("reset_cy", int'(cy), 0);
        chk("reset_pix_count", int'(pix_count), 0);
        chk("reset_found", int'(found), 0);
        chk("reset_result_valid", int'(result_valid), 0);
        chk("reset_busy", int'(busy), 0);
        resetn = 1'b1;
        repeat (2) tick();

        // single bright pixel at (5,2)
        fill(8'd0);
        img[2][5] = 8'd200;
        send_frame(COLS, 1'b1, 5, 2, 1, DIV_W + 2);
        wait_result();

        // 2x2 block at threshold value: sum_x=10, sum_y=6, count=4
        fill(8'd0);
        img[1][2] = 8'd128; img[1][3] = 8'd128;
        img[2][2] = 8'd128; img[2][3] = 8'd128;
        send_frame(COLS, 1'b1, 2, 1, 4, DIV_W + 2);
        wait_result();

        // nothing bright: divider skipped
        fill(8'd127);
        send_frame(COLS, 1'b1, 0, 0, 0, 2);
        wait_result();

        // corners: sum_x=14, sum_y=3, count=3 -> floor 4, 1
        fill(8'd10);
        img[0][0] = 8'd255; img[3][7] = 8'd255; img[0][7] = 8'd129;
        send_frame(COLS, 1'b1, 4, 1, 3, DIV_W + 2);
        wait_result();

        // 10 beats per line, bright extras past the last column
        fill(8'd0);
        img[3][6] = 8'd255;
        send_frame(COLS + 2, 1'b1, 6, 3, 1, DIV_W + 2);
        wait_result();

        // abort mid-DIVIDE, then a full frame with (1,3) bright
        fill(8'd0);
        img[0][7] = 8'd250;
        send_frame(COLS, 1'b0, 0, 0, 0, 0);
        repeat (5) tick();
        chk("busy_in_divide", int'(busy), 1);
        fill(8'd0);
        img[3][1] = 8'd200;
        send_frame(COLS, 1'b1, 1, 3, 1, DIV_W + 2);
        wait_result();

        // reset during ACCUM clears outputs at once, no pulse
        fill(8'd0);
        img[1][4] = 8'd250;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) begin
            line_valid = 1'b1; data_valid = 1'b1; pixel = 8'd255;
            tick();
        end
        resetn = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_cx", int'(cx), 0);
        chk("rst_cy", int'(cy), 0);
        chk("rst_pix_count", int'(pix_count), 0);
        chk("rst_found", int'(found), 0);
        line_valid = 1'b0; data_valid = 1'b0; pixel = 8'd0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (2) tick();
        send_frame(COLS, 1'b1, 4, 1, 1, DIV_W + 2);
        wait_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
